// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//   Serial pattern transmitter. A start request sends `repeats` copies of
//   PATTERN, MSB first, on a single-bit line. Consecutive copies are separated
//   by `gap` zero bits. Holding en low inserts bubbles without losing stream
//   position.
// Parameters:
//   PATTERN_LEN  pattern length in bits (2..16)
//   PATTERN      pattern value; bit PATTERN_LEN-1 is sent first
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start    transmission request, sampled only in IDLE together with en
//   repeats  number of pattern copies, latched at start
//   gap      zero bits between copies, latched at start
//   en       advance enable; 0 inserts a bubble
//   out      serial data bit (registered)
//   valid    out carries a stream bit this cycle (registered)
//   busy     transmission in progress, SEND or GAP (registered)
//   done     one-cycle completion pulse (registered)
module serial_pattern_gen #(
  parameter int                     PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b10001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] repeats,
  input  logic [3:0] gap,
  input  logic       en,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int IDX_W = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;

  // Reorders the pattern so that element k is the k-th bit on the wire.
  function automatic logic [PATTERN_LEN-1:0] reverse_bits(input logic [PATTERN_LEN-1:0] v);
    logic [PATTERN_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < PATTERN_LEN; i++) begin
      r[i] = v[PATTERN_LEN-1-i];
    end
    return r;
  endfunction

  localparam logic [PATTERN_LEN-1:0] PAT_SEQ   = reverse_bits(PATTERN);
  localparam logic                   FIRST_BIT = PAT_SEQ[0];
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(PATTERN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       copy_r, copy_s;        // copies still to send, incl. current
  logic [3:0]       gap_len_r, gap_len_s;  // latched gap length
  logic [3:0]       gap_cnt_r, gap_cnt_s;  // zeros still to send after the current one
  logic [IDX_W-1:0] idx_r, idx_s;          // index of the bit currently presented
  logic [IDX_W-1:0] idx_inc_s;
  logic             out_r, out_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  assign idx_inc_s = idx_r + IDX_W'(1);

  // Next-state and next-output logic; valid/done default low, everything else holds.
  always_comb begin
    state_s   = state_r;
    copy_s    = copy_r;
    gap_len_s = gap_len_r;
    gap_cnt_s = gap_cnt_r;
    idx_s     = idx_r;
    out_s     = out_r;
    valid_s   = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        out_s  = 1'b0;
        busy_s = 1'b0;
        if (start && en) begin
          if (repeats != 8'd0) begin
            state_s   = SEND;
            copy_s    = repeats;
            gap_len_s = gap;
            gap_cnt_s = 4'd0;
            idx_s     = '0;
            out_s     = FIRST_BIT;
            valid_s   = 1'b1;
            busy_s    = 1'b1;
          end else begin
            // Zero copies: complete immediately without sending anything.
            state_s = DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (!en) begin
          valid_s = 1'b0;
        end else if (idx_r != LAST_IDX) begin
          idx_s   = idx_inc_s;
          out_s   = PAT_SEQ[idx_inc_s];
          valid_s = 1'b1;
        end else if (copy_r > 8'd1) begin
          copy_s = copy_r - 8'd1;
          if (gap_len_r != 4'd0) begin
            state_s   = GAP;
            out_s     = 1'b0;
            valid_s   = 1'b1;
            gap_cnt_s = gap_len_r - 4'd1;
          end else begin
            idx_s   = '0;
            out_s   = FIRST_BIT;
            valid_s = 1'b1;
          end
        end else begin
          state_s = DONE;
          out_s   = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end
      end
      GAP: begin
        if (!en) begin
          valid_s = 1'b0;
        end else if (gap_cnt_r != 4'd0) begin
          gap_cnt_s = gap_cnt_r - 4'd1;
          out_s     = 1'b0;
          valid_s   = 1'b1;
        end else begin
          state_s = SEND;
          idx_s   = '0;
          out_s   = FIRST_BIT;
          valid_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
        out_s   = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        out_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      copy_r    <= 8'd0;
      gap_len_r <= 4'd0;
      gap_cnt_r <= 4'd0;
      idx_r     <= '0;
      out_r     <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      copy_r    <= copy_s;
      gap_len_r <= gap_len_s;
      gap_cnt_r <= gap_cnt_s;
      idx_r     <= idx_s;
      out_r     <= out_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign out   = out_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen
//   Directed bench for serial_pattern_gen with the default 5-bit 10001 pattern.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] repeats;
  logic [3:0] gap;
  logic       en;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;

  int total;
  int bad;

  serial_pattern_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .repeats (repeats),
    .gap     (gap),
    .en      (en),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transmission and checks bits, bit count, done cycle and busy/out.
  // Cycle c is the c-th cycle after the start edge E0; the loop always ends at exp_done+1.
  task automatic run(input string name, input logic [7:0] rep, input logic [3:0] gp,
                     input bit toggle_en, input bit disturb,
                     input int exp_n, input logic [31:0] exp_bits, input int exp_done);
    logic [31:0] bits;
    int n, done_cyc, done_cnt, busy_err, out_err;
    bits = 32'd0; n = 0; done_cyc = 0; done_cnt = 0; busy_err = 0; out_err = 0;
    @(negedge clk);
    start = 1'b1; en = 1'b1; repeats = rep; gap = gp;
    @(posedge clk);
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        bits = {bits[30:0], out};
        n++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy !== (c < exp_done)) busy_err++;
      if (busy !== 1'b1 && out !== 1'b0) out_err++;
      // Inputs for the edge that ends cycle c.
      start = disturb && (c == 3 || c == 4);
      if (disturb && c == 3) begin
        repeats = 8'd5;
        gap     = 4'd7;
      end
      en = toggle_en ? ((c % 2) == 1) : 1'b1;
    end
    en = 1'b1;
    chk({name, " nbits"}, n, exp_n);
    chk({name, " bits"}, bits, exp_bits);
    chk({name, " done_cycle"}, done_cyc, exp_done);
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " busy_errs"}, busy_err, 0);
    chk({name, " out_idle_errs"}, out_err, 0);
  endtask

  initial begin
    logic [31:0] rbits;
    int          rdone;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; repeats = 8'd0; gap = 4'd0; en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {28'd0, out, valid, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {28'd0, out, valid, busy, done}, 32'd0);

    run("r1g0",    8'd1, 4'd0, 1'b0, 1'b0, 5,  32'b10001,           6);
    run("r2g3",    8'd2, 4'd3, 1'b0, 1'b0, 13, 32'b1000100010001,   14);
    run("r3g0",    8'd3, 4'd0, 1'b0, 1'b0, 15, 32'b100011000110001, 16);
    run("r2g1",    8'd2, 4'd1, 1'b0, 1'b0, 11, 32'b10001010001,     12);
    run("r1_stall",8'd1, 4'd0, 1'b1, 1'b0, 5,  32'b10001,           10);
    run("r2g3_dist",8'd2,4'd3, 1'b0, 1'b1, 13, 32'b1000100010001,   14);

    // Reset after the third bit of a two-copy stream.
    @(negedge clk);
    start = 1'b1; en = 1'b1; repeats = 8'd2; gap = 4'd0;
    @(posedge clk);
    rbits = 32'd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid === 1'b1) rbits = {rbits[30:0], out};
    end
    chk("abort_prefix", rbits, 32'b100);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {28'd0, out, valid, busy, done}, 32'd0);
    rdone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1 || valid === 1'b1) rdone++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1 || valid === 1'b1) rdone++;
    end
    chk("abort_no_done", rdone, 0);

    run("r0", 8'd0, 4'd0, 1'b0, 1'b0, 0, 32'd0, 1);

    // Start edge coinciding with reset: nothing may be latched.
    @(negedge clk);
    start = 1'b1; en = 1'b1; repeats = 8'd1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    rdone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1 || done === 1'b1) rdone++;
    end
    chk("rst_vs_start", rdone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
